// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default widths and the sequential PC step.
package fetch_unit_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned PC_INCR           = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    DROP     = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry FIFO holding fetched {instruction, pc} pairs for decode.
// Flush wins over push/pop; push is accepted when full only if a pop
// frees a slot in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time,
// tags each response with its granted PC, buffers up to two fetched words
// and steers the next PC (sequential, hold, or redirect target).
//
// Decode channel handshake: instr_valid_o/instr_o/instr_pc_o present the FIFO
// head; a word transfers on a rising edge where instr_valid_o && instr_ready_i
// (and no redirect). While valid is high and ready is low the payload holds.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  output logic [ADDRESS_WIDTH-1:0] pc_next_o,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_addr_i,
  output logic                     imem_req_o,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
  output logic                     instr_valid_o,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] instr_pc_o,
  input  logic                     instr_ready_i,
  output fetch_state_e             state_o
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(PC_INCR);
  localparam int unsigned ENTRY_W = DATA_WIDTH + ADDRESS_WIDTH;

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] tag_q, tag_d;
  logic                     grant_taken;
  logic                     push;
  logic                     pop;
  logic                     outstanding;
  logic                     issue_ok;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [1:0]               fifo_count;
  logic [ENTRY_W-1:0]       fifo_head;

  assign state_o     = state_q;
  assign imem_addr_o = address_i;
  assign outstanding = (state_q == WAIT_RSP) || (state_q == DROP);
  assign issue_ok    = (({1'b0, fifo_count} + {2'b00, outstanding}) < 3'd2);

  // FSM next state, request strobe and response capture; redirect dominates.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    imem_req_o  = 1'b0;
    grant_taken = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect_i && issue_ok) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        imem_req_o = !rst;
        if (imem_gnt_i) begin
          grant_taken = 1'b1;
          tag_d       = address_i;
          state_d     = redirect_i ? DROP : WAIT_RSP;
        end else if (redirect_i) begin
          state_d = IDLE;
        end
      end
      WAIT_RSP: begin
        if (imem_rvalid_i) begin
          // A response landing with a redirect is stale: discard it, but the
          // transaction is complete so there is nothing left to drop.
          state_d = IDLE;
          push    = !redirect_i && !fifo_full;
        end else if (redirect_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-PC steering: pc_counter owns the reset value, so hold during reset.
  always_comb begin
    pc_next_o = address_i;
    if (!rst) begin
      if (redirect_i)       pc_next_o = redirect_addr_i;
      else if (grant_taken) pc_next_o = address_i + PC_STEP;
    end
  end

  // FSM state and response tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign instr_valid_o = !fifo_empty && !rst;
  assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_o       = rst ? '0 : fifo_head[ENTRY_W-1:ADDRESS_WIDTH];
  assign instr_pc_o    = rst ? '0 : fifo_head[ADDRESS_WIDTH-1:0];

  fetch_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  ({imem_rdata_i, tag_q}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models pc_counter and a simple instruction memory,
// drives directed scenarios and checks decode output against hand-listed PCs.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  address_i = '0;
  logic [31:0]  pc_next_o;
  logic         redirect_i = 1'b0;
  logic [31:0]  redirect_addr_i = '0;
  logic         imem_req_o;
  logic [31:0]  imem_addr_o;
  logic         imem_gnt_i = 1'b0;
  logic         imem_rvalid_i = 1'b0;
  logic [31:0]  imem_rdata_i = '0;
  logic         instr_valid_o;
  logic [31:0]  instr_o;
  logic [31:0]  instr_pc_o;
  logic         instr_ready_i = 1'b0;
  fetch_state_e state_o;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .address_i       (address_i),
    .pc_next_o       (pc_next_o),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i),
    .state_o         (state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Memory / pc_counter model state
  logic [31:0] pc_reset_val = '0;
  int          grants_left = 0;
  int          grant_cnt = 0;
  int          rsp_delay = 1;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic        s_req = 1'b0, s_gnt = 1'b0, s_rst = 1'b1;
  logic [31:0] s_addr = '0, s_pc_next = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // pc_counter and instruction memory: act just after each rising edge on
  // values sampled late in the previous cycle.
  always @(posedge clk) begin
    #1;
    address_i     = s_rst ? pc_reset_val : s_pc_next;
    imem_rvalid_i = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend_addr);
        pend          = 1'b0;
      end
    end
    if (s_req && s_gnt) begin
      grant_cnt++;
      if (grants_left > 0) grants_left--;
      if (rsp_delay <= 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(s_addr);
      end else begin
        pend      = 1'b1;
        pend_cnt  = rsp_delay - 1;
        pend_addr = s_addr;
      end
    end
    imem_gnt_i = (grants_left > 0);
  end

  // Sampler and monitor: late in the low phase, after all inputs settle.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] nxt;
    #2;
    s_req     = imem_req_o;
    s_gnt     = imem_gnt_i;
    s_addr    = imem_addr_o;
    s_pc_next = pc_next_o;
    s_rst     = rst;
    if (!rst) begin
      if (redirect_i) begin
        chk("pc_next_redirect", pc_next_o, redirect_addr_i);
      end else if (imem_req_o && imem_gnt_i) begin
        nxt = imem_addr_o + 32'd4;
        chk("pc_next_grant", pc_next_o, nxt);
      end
      if (instr_valid_o && instr_ready_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %0h expected none", instr_pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc_o, e);
          chk("instr_data", instr_o, mem_word(e));
        end
      end
    end
  end

  // Driver tasks (called at falling edges)
  task automatic do_reset(input logic [31:0] pc0, input int grants, input int dly,
                          input logic rdy);
    @(negedge clk);
    rst           = 1'b1;
    redirect_i    = 1'b0;
    instr_ready_i = rdy;
    pc_reset_val  = pc0;
    rsp_delay     = dly;
    grants_left   = grants;
    grant_cnt     = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_instr_pc", instr_pc_o, 32'd0);
    chk("rst_pc_next", pc_next_o, pc0);
    rst = 1'b0;
  endtask

  task automatic wait_state(input fetch_state_e s, input int budget);
    int n = 0;
    while (state_o !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (state_o !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: got %0d expected %0d", state_o, s);
    end
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int budget);
    int n = 0;
    while (!(imem_req_o === 1'b1 && imem_addr_o === a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(imem_req_o === 1'b1 && imem_addr_o === a)) begin
      checks++;
      errors++;
      $display("FAIL wait_req: got addr %0h expected %0h", imem_addr_o, a);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Directed scenarios
  initial begin
    // Sequential fetch from 0 with immediate grant and 1-cycle response
    do_reset(32'h0, 4, 1, 1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    wait_drain(100);

    // Decode stalled: two entries buffered, request held off, head stable
    do_reset(32'h0, 4, 1, 1'b0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    repeat (5) @(negedge clk);
    chk("stall_head_pc_early", instr_pc_o, 32'h0);
    repeat (5) @(negedge clk);
    chk("stall_valid", 32'(instr_valid_o), 32'd1);
    chk("stall_req", 32'(imem_req_o), 32'd0);
    chk("stall_grants", 32'(grant_cnt), 32'd2);
    chk("stall_head_pc_late", instr_pc_o, 32'h0);
    chk("stall_head_data", instr_o, mem_word(32'h0));
    instr_ready_i = 1'b1;
    wait_drain(100);

    // Redirect while waiting for a response: that response is dropped
    do_reset(32'h0, 2, 3, 1'b1);
    exp_q.push_back(32'h100);
    wait_state(WAIT_RSP, 20);
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h100;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("drop_after_rsp_redirect", 32'(state_o), 32'(DROP));
    wait_drain(100);

    // Redirect in the grant cycle of 0x8: word for 0x8 must never appear
    do_reset(32'h0, 5, 1, 1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    wait_req_addr(32'h8, 50);
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h200;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("drop_after_gnt_redirect", 32'(state_o), 32'(DROP));
    wait_drain(100);

    // Redirect flushes a full FIFO and wins over a same-cycle pop
    do_reset(32'h0, 3, 1, 1'b0);
    exp_q.push_back(32'h300);
    repeat (8) @(negedge clk);
    chk("flush_pre_valid", 32'(instr_valid_o), 32'd1);
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h300;
    instr_ready_i   = 1'b1;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("flush_valid", 32'(instr_valid_o), 32'd0);
    wait_drain(100);

    // PC wrap at the top of the address space
    do_reset(32'hFFFF_FFFC, 2, 1, 1'b1);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    wait_drain(100);

    // Reset in WAIT_RSP, late response the cycle after must be ignored
    do_reset(32'h0, 1, 2, 1'b1);
    wait_state(WAIT_RSP, 20);
    rst = 1'b1;
    @(negedge clk);
    chk("late_rsp_state", 32'(state_o), 32'(IDLE));
    chk("late_rsp_rvalid_seen", 32'(imem_rvalid_i), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_rsp_valid", 32'(instr_valid_o), 32'd0);
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
